mux_scan_sequencer: RTL and testbench
=====================================

// Module: mux_scan_sequencer
// PURPOSE
//  Sequential controller for the 4:1 select mux stage (data A..D, selects S/T, output O).
//  Drives {S,T} to walk channels 0..3 and waits a settle time on each channel.
//  Then samples the mux output into a 4-bit frame, with one bit per channel.
//  Replaces the free-running toggle-based select generation; feeds a 4-bit snapshot downstream.
// PARAMETERS
//  SETTLE   2   clocks to hold each select before sampling O (legal range 1..15)
// PORTS
//  clk          in   1  single system clock, rising-edge
//  rst          in   1  asynchronous, active-high reset
//  start        in   1  request one scan frame (sampled only in IDLE)
//  continuous   in   1  1: restart a new frame automatically after DONE
//  mask         in   4  channel enable, bit i = channel i ({S,T}=i); latched at frame start
//  mux_o        in   1  output O of the 4:1 mux
//  S            out  1  mux select MSB (channel index bit 1)
//  T            out  1  mux select LSB (channel index bit 0)
//  busy         out  1  high in SETTLE/SAMPLE/DONE
//  frame_valid  out  1  one-cycle pulse: frame holds a new snapshot
//  frame        out  4  bit i = sampled O for channel i; masked channels read 0
// BEHAVIOUR
//  Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
//  Reset: state=IDLE, {S,T}=2'b00, busy=0, frame_valid=0, frame=4'b0, latched mask=0, shadow=0, cnt=0.
//  FSM states: IDLE, SETTLE, SAMPLE, DONE.
//  IDLE: start=1 and mask!=0 -> latch mask, clear shadow, set {S,T}=lowest set mask bit, cnt=0 -> SETTLE.
//    start with mask==0 is ignored (remain IDLE, busy=0).
//  SETTLE: cnt increments each clock; at cnt==SETTLE-1 -> SAMPLE. {S,T} stable throughout.
//  SAMPLE (1 clk): shadow[{S,T}] <= mux_o.
//    Next higher set bit in latched mask exists -> {S,T}=that index, cnt=0 -> SETTLE.
//    Otherwise -> DONE. No wrap from ch3 to ch0 within a frame.
//  DONE (1 clk): frame <= shadow, frame_valid=1 this cycle only.
//    continuous=1 -> relatch mask; if nonzero, go to first channel as in IDLE, else IDLE.
//    continuous=0 -> IDLE.
//  Latency: each enabled channel costs SETTLE+1 clocks.
//    frame_valid rises N*(SETTLE+1)+1 clocks after the start edge (N = enabled channels).
//    Example: SETTLE=2 with all 4 enabled gives 13 clocks.
//  frame holds its value between pulses. {S,T} hold the last channel in IDLE.
//  start, mask and continuous changes mid-frame have no effect on the current frame.
//  The mask is relatched only at frame start. continuous is sampled in DONE.
//  rst mid-frame: immediate return to reset values. The partial frame is discarded and no frame_valid is issued.
//  Counter width: 4 bits. SETTLE=1 gives 2 clocks per channel.
// TESTING
//  1 rst=1 mid-SETTLE -> S=T=0, busy=0, frame=0 asynchronously; no frame_valid afterwards.
//  2 SETTLE=2, mask=1111, mux_o driven = A..D = 1,0,1,1 per select, start pulse
//    -> {S,T} steps 00,01,10,11 every 3 clks; frame_valid at clk 13; frame=4'b1101 (bit0=A).
//  3 mask=0101, mux_o=1 always -> only {S,T}=00,10 visited; frame_valid at clk 7; frame=4'b0101.
//  4 mask=0000, start=1 -> busy stays 0, frame_valid never asserts, {S,T} stays 00.
//  5 continuous=1, mask=1000 -> frame_valid every 4 clks.
//    Change mask to 0001 mid-frame -> it takes effect only on the next frame.
//  6 Glitch check: mux_o toggled during SETTLE, stable in SAMPLE -> frame holds the SAMPLE-cycle value.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 4:1 select mux: walks the enabled channels, waits SETTLE
// clocks on each, samples the mux output, and publishes a 4-bit frame snapshot.
module mux_scan_sequencer #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       continuous,
    input  logic [3:0] mask,
    input  logic       mux_o,
    output logic       S,
    output logic       T,
    output logic       busy,
    output logic       frame_valid,
    output logic [3:0] frame
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t     state, state_n;
    logic [1:0] sel, sel_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] mask_q, mask_n;
    logic [3:0] shadow, shadow_n;
    logic [3:0] frame_n;
    logic       frame_valid_n;
    logic [2:0] next_hit;

    function automatic logic [1:0] first_chan(input logic [3:0] m);
        first_chan = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) first_chan = 2'(i);
        end
    endfunction

    // Returns {found, index} of the lowest enabled channel above cur; never wraps.
    function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] cur);
        next_above = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) next_above = {1'b1, 2'(i)};
        end
    endfunction

    assign next_hit = next_above(mask_q, sel);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        state_n       = state;
        sel_n         = sel;
        cnt_n         = cnt;
        mask_n        = mask_q;
        shadow_n      = shadow;
        frame_n       = frame;
        frame_valid_n = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start && (mask != 4'b0000)) begin
                    mask_n   = mask;
                    shadow_n = 4'b0000;
                    sel_n    = first_chan(mask);
                    cnt_n    = 4'd0;
                    state_n  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == CNT_LAST) begin
                    state_n = ST_SAMPLE;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            ST_SAMPLE: begin
                shadow_n[sel] = mux_o;
                if (next_hit[2]) begin
                    sel_n   = next_hit[1:0];
                    cnt_n   = 4'd0;
                    state_n = ST_SETTLE;
                end else begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_n       = shadow;
                frame_valid_n = 1'b1;
                state_n       = ST_IDLE;
                if (continuous) begin
                    mask_n = mask;
                    if (mask != 4'b0000) begin
                        shadow_n = 4'b0000;
                        sel_n    = first_chan(mask);
                        cnt_n    = 4'd0;
                        state_n  = ST_SETTLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            sel         <= 2'b00;
            cnt         <= 4'd0;
            mask_q      <= 4'b0000;
            shadow      <= 4'b0000;
            frame       <= 4'b0000;
            frame_valid <= 1'b0;
        end else begin
            state       <= state_n;
            sel         <= sel_n;
            cnt         <= cnt_n;
            mask_q      <= mask_n;
            shadow      <= shadow_n;
            frame       <= frame_n;
            frame_valid <= frame_valid_n;
        end
    end

    assign S    = sel[1];
    assign T    = sel[0];
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer: stimulus pushes expected frames and
// their arrival cycle; a monitor pops and compares on every frame_valid pulse.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       continuous;
    logic [3:0] mask;
    logic       mux_o;
    logic       S;
    logic       T;
    logic       busy;
    logic       frame_valid;
    logic [3:0] frame;

    logic [3:0] data;
    logic       force_en;
    logic       force_val;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [3:0] frame;
        int         at;
    } exp_t;

    exp_t sb[$];

    mux_scan_sequencer #(.SETTLE(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .continuous  (continuous),
        .mask        (mask),
        .mux_o       (mux_o),
        .S           (S),
        .T           (T),
        .busy        (busy),
        .frame_valid (frame_valid),
        .frame       (frame)
    );

    always #5 clk = ~clk;

    // Behavioural 4:1 mux: channel {S,T} selects data bit, optionally overridden.
    assign mux_o = force_en ? force_val : data[{S, T}];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && frame_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_frame_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("frame", 32'(frame), 32'(e.frame));
                check("frame_time", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; returns on the negedge right after the start edge s.
    task automatic start_frame(input logic [3:0] m, input logic push, input logic [3:0] f,
                               input int lat, output int s);
        mask  = m;
        start = 1'b1;
        s     = cyc + 1;
        if (push) sb.push_back('{f, s + lat});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string name, input int bound);
        int k = 0;
        while (sb.size() != 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        rst        = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        mask       = 4'b0000;
        data       = 4'b0000;
        force_en   = 1'b0;
        force_val  = 1'b0;

        tick(2);
        check("reset_sel", 32'({S, T}), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_frame_valid", 32'(frame_valid), 32'd0);
        check("reset_frame", 32'(frame), 32'd0);
        rst = 1'b0;
        tick(1);

        // start with an empty mask is ignored
        mask  = 4'b0000;
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("empty_mask_busy", 32'(busy), 32'd0);
            check("empty_mask_sel", 32'({S, T}), 32'd0);
        end
        start = 1'b0;

        // all four channels, A..D = 1,0,1,1
        data = 4'b1101;
        start_frame(4'b1111, 1'b1, 4'b1101, 13, s);
        mask = 4'b0000;
        for (int m = 0; m < 4; m++) begin
            check("full_scan_sel", 32'({S, T}), 32'(m));
            check("full_scan_busy", 32'(busy), 32'd1);
            tick(3);
        end
        drain("full_scan_drain", 10);
        check("full_scan_hold_sel", 32'({S, T}), 32'd3);
        check("full_scan_idle", 32'(busy), 32'd0);

        // sparse mask: masked channels read 0 even though O is 1
        data = 4'b1111;
        start_frame(4'b0101, 1'b1, 4'b0101, 7, s);
        check("sparse_sel0", 32'({S, T}), 32'd0);
        tick(3);
        check("sparse_sel2", 32'({S, T}), 32'd2);
        drain("sparse_drain", 10);
        check("sparse_hold_sel", 32'({S, T}), 32'd2);

        // continuous mode; mask change mid-frame applies to the next frame only
        continuous = 1'b1;
        data       = 4'b1001;
        start_frame(4'b1000, 1'b1, 4'b1000, 4, s);
        sb.push_back('{4'b0001, s + 8});
        sb.push_back('{4'b0001, s + 12});
        check("cont_sel_first", 32'({S, T}), 32'd3);
        tick(1);
        mask = 4'b0001;
        tick(4);
        check("cont_sel_second", 32'({S, T}), 32'd0);
        tick(4);
        continuous = 1'b0;
        drain("cont_drain", 20);
        tick(6);
        check("cont_stopped", 32'(busy), 32'd0);

        // glitches on O during SETTLE are ignored; the SAMPLE-cycle value is kept
        force_en  = 1'b1;
        force_val = 1'b0;
        start_frame(4'b0001, 1'b1, 4'b0001, 4, s);
        force_val = 1'b1;
        tick(1);
        force_val = 1'b0;
        tick(1);
        force_val = 1'b1;
        tick(1);
        force_val = 1'b0;
        drain("glitch_drain", 10);
        force_en = 1'b0;

        // asynchronous reset mid-SETTLE discards the partial frame
        data = 4'b1111;
        start_frame(4'b1110, 1'b0, 4'b0000, 0, s);
        check("abort_busy_before", 32'(busy), 32'd1);
        check("abort_sel_before", 32'({S, T}), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_sel", 32'({S, T}), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_frame", 32'(frame), 32'd0);
        check("abort_frame_valid", 32'(frame_valid), 32'd0);
        mask = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        tick(30);
        check("abort_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
